// File: rtl/block_transfer_unit_pkg.sv
// Shared definitions for the block transfer unit: FSM states and
// architectural constants used by the top level and its helpers.
package block_transfer_unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER   = 2'd1,
        WRBACK = 2'd2,
        DONE   = 2'd3
    } xferState_t;

    localparam logic [3:0]  REG_PC     = 4'd15;
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/block_transfer_unit_priority_encoder16.sv
// Lowest-set-bit finder: returns the index of the least significant set bit
// of a 16-bit mask, with valid low when the mask is empty.
module priority_encoder16 (
    input  logic [15:0] mask,
    output logic [3:0]  index,
    output logic        valid
);

    always_comb begin
        index = '0;
        valid = |mask;
        // Walk from the top so the lowest set bit is the last one written.
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                index = 4'(i);
            end
        end
    end

endmodule

// File: rtl/block_transfer_unit.sv
// Load/store-multiple sequencer: walks a 16-bit register mask lowest-first,
// issuing one word memory request per selected register, with optional base writeback.
module block_transfer_unit
    import block_transfer_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        isLoad,
    input  logic [15:0] regList,
    input  logic [31:0] baseAddr,
    input  logic [3:0]  baseReg,
    input  logic        writeBack,
    output logic [3:0]  regReadAddr,
    input  logic [31:0] regReadData,
    output logic        regWriteEnable,
    output logic [3:0]  regWriteDest,
    output logic [31:0] regWriteData,
    output logic        memReq,
    output logic        memWrite,
    output logic [31:0] memAddr,
    output logic [31:0] memWriteData,
    input  logic        memAck,
    input  logic [31:0] memReadData,
    output logic        busy,
    output logic        done,
    output logic        pcLoad
);

    xferState_t  state;
    xferState_t  nextState;
    logic [15:0] regMask;
    logic [31:0] curAddr;
    logic [3:0]  baseRegQ;
    logic        isLoadQ;
    logic        wbNeeded;

    logic [3:0]  curIdx;
    logic        curValid;
    logic [15:0] curBit;
    logic [15:0] remainMask;

    priority_encoder16 lowestSel (
        .mask  (regMask),
        .index (curIdx),
        .valid (curValid)
    );

    assign curBit     = 16'h0001 << curIdx;
    assign remainMask = regMask & ~curBit;

    // Control state: cleared asynchronously so a mid-transfer reset abandons the block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            regMask  <= '0;
            isLoadQ  <= 1'b0;
            wbNeeded <= 1'b0;
        end else begin
            state <= nextState;
            if (state == IDLE && start) begin
                regMask  <= regList;
                isLoadQ  <= isLoad;
                // A load that overwrites the base register keeps the loaded value.
                wbNeeded <= writeBack && !(isLoad && regList[baseReg]);
            end else if (state == XFER && memAck) begin
                regMask <= remainMask;
            end
        end
    end

    // Address and base index are only observed outside IDLE, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            curAddr  <= baseAddr;
            baseRegQ <= baseReg;
        end else if (state == XFER && memAck) begin
            curAddr <= curAddr + WORD_BYTES;
        end
    end

    always_comb begin
        nextState      = state;
        regReadAddr    = '0;
        regWriteEnable = 1'b0;
        regWriteDest   = '0;
        regWriteData   = '0;
        memReq         = 1'b0;
        memWrite       = 1'b0;
        memAddr        = '0;
        memWriteData   = '0;
        busy           = 1'b0;
        done           = 1'b0;
        pcLoad         = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    nextState = (regList != 16'h0000) ? XFER : DONE;
                end
            end
            XFER: begin
                busy     = 1'b1;
                memReq   = curValid;
                memWrite = !isLoadQ;
                memAddr  = curAddr;
                if (!isLoadQ) begin
                    regReadAddr  = curIdx;
                    memWriteData = regReadData;
                end
                if (memAck) begin
                    if (isLoadQ) begin
                        regWriteEnable = 1'b1;
                        regWriteDest   = curIdx;
                        regWriteData   = memReadData;
                        pcLoad         = (curIdx == REG_PC);
                    end
                    if (remainMask == 16'h0000) begin
                        nextState = wbNeeded ? WRBACK : DONE;
                    end
                end
            end
            WRBACK: begin
                // After the last ack curAddr already equals base + 4 * popcount(regList).
                busy           = 1'b1;
                regWriteEnable = 1'b1;
                regWriteDest   = baseRegQ;
                regWriteData   = curAddr;
                nextState      = DONE;
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_block_transfer_unit.sv
// Directed bench for block_transfer_unit with a combinational register file
// and memory model; expected values are written out per cycle.
module tb_block_transfer_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        isLoad;
    logic [15:0] regList;
    logic [31:0] baseAddr;
    logic [3:0]  baseReg;
    logic        writeBack;
    logic [3:0]  regReadAddr;
    logic [31:0] regReadData;
    logic        regWriteEnable;
    logic [3:0]  regWriteDest;
    logic [31:0] regWriteData;
    logic        memReq;
    logic        memWrite;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic        memAck;
    logic [31:0] memReadData;
    logic        busy;
    logic        done;
    logic        pcLoad;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Register Rn reads as 0x1000_000n; memory word at A reads as A + 0x5500_0000.
    assign regReadData = 32'h1000_0000 | {28'h0, regReadAddr};
    assign memReadData = memAddr + 32'h5500_0000;

    block_transfer_unit dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .isLoad         (isLoad),
        .regList        (regList),
        .baseAddr       (baseAddr),
        .baseReg        (baseReg),
        .writeBack      (writeBack),
        .regReadAddr    (regReadAddr),
        .regReadData    (regReadData),
        .regWriteEnable (regWriteEnable),
        .regWriteDest   (regWriteDest),
        .regWriteData   (regWriteData),
        .memReq         (memReq),
        .memWrite       (memWrite),
        .memAddr        (memAddr),
        .memWriteData   (memWriteData),
        .memAck         (memAck),
        .memReadData    (memReadData),
        .busy           (busy),
        .done           (done),
        .pcLoad         (pcLoad)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic kick(input logic ld, input logic [15:0] lst, input logic [31:0] addr,
                        input logic [3:0] br, input logic wb);
        start     = 1'b1;
        isLoad    = ld;
        regList   = lst;
        baseAddr  = addr;
        baseReg   = br;
        writeBack = wb;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; isLoad = 1'b0; regList = '0;
        baseAddr = '0; baseReg = '0; writeBack = 1'b0; memAck = 1'b0;

        #2;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_req", {31'h0, memReq}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // STM R0,R2 from 0x100, immediate acks
        @(negedge clk);
        chk("idle_addr", memAddr, 32'h0);
        chk("idle_we", {31'h0, regWriteEnable}, 32'h0);
        kick(1'b0, 16'h0005, 32'h0000_0100, 4'd0, 1'b0);
        memAck = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("stm_c1_req", {31'h0, memReq}, 32'h1);
        chk("stm_c1_wr", {31'h0, memWrite}, 32'h1);
        chk("stm_c1_addr", memAddr, 32'h0000_0100);
        chk("stm_c1_rra", {28'h0, regReadAddr}, 32'h0);
        chk("stm_c1_wd", memWriteData, 32'h1000_0000);
        chk("stm_c1_we", {31'h0, regWriteEnable}, 32'h0);
        chk("stm_c1_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        chk("stm_c2_addr", memAddr, 32'h0000_0104);
        chk("stm_c2_rra", {28'h0, regReadAddr}, 32'h2);
        chk("stm_c2_wd", memWriteData, 32'h1000_0002);
        chk("stm_c2_done", {31'h0, done}, 32'h0);
        @(negedge clk);
        chk("stm_c3_done", {31'h0, done}, 32'h1);
        chk("stm_c3_busy", {31'h0, busy}, 32'h0);
        chk("stm_c3_req", {31'h0, memReq}, 32'h0);

        // LDM R1,R15 from 0x200 with writeback to R3
        @(negedge clk);
        chk("stm_c4_done", {31'h0, done}, 32'h0);
        kick(1'b1, 16'h8002, 32'h0000_0200, 4'd3, 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk("ldm_c1_wr", {31'h0, memWrite}, 32'h0);
        chk("ldm_c1_addr", memAddr, 32'h0000_0200);
        chk("ldm_c1_we", {31'h0, regWriteEnable}, 32'h1);
        chk("ldm_c1_dst", {28'h0, regWriteDest}, 32'h1);
        chk("ldm_c1_wdat", regWriteData, 32'h5500_0200);
        chk("ldm_c1_pc", {31'h0, pcLoad}, 32'h0);
        @(negedge clk);
        chk("ldm_c2_addr", memAddr, 32'h0000_0204);
        chk("ldm_c2_dst", {28'h0, regWriteDest}, 32'hF);
        chk("ldm_c2_wdat", regWriteData, 32'h5500_0204);
        chk("ldm_c2_pc", {31'h0, pcLoad}, 32'h1);
        @(negedge clk);
        chk("ldm_wb_we", {31'h0, regWriteEnable}, 32'h1);
        chk("ldm_wb_dst", {28'h0, regWriteDest}, 32'h3);
        chk("ldm_wb_dat", regWriteData, 32'h0000_0208);
        chk("ldm_wb_busy", {31'h0, busy}, 32'h1);
        chk("ldm_wb_req", {31'h0, memReq}, 32'h0);
        chk("ldm_wb_pc", {31'h0, pcLoad}, 32'h0);
        @(negedge clk);
        chk("ldm_c4_done", {31'h0, done}, 32'h1);
        chk("ldm_c4_we", {31'h0, regWriteEnable}, 32'h0);

        // Empty list: done next cycle, no memory traffic
        @(negedge clk);
        kick(1'b0, 16'h0000, 32'h0000_0300, 4'd1, 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk("empty_done", {31'h0, done}, 32'h1);
        chk("empty_req", {31'h0, memReq}, 32'h0);
        chk("empty_we", {31'h0, regWriteEnable}, 32'h0);

        // STM R1,R4 with three wait cycles per request; start mid-transfer ignored
        @(negedge clk);
        chk("empty_idle", {31'h0, done}, 32'h0);
        memAck = 1'b0;
        kick(1'b0, 16'h0012, 32'h0000_0300, 4'd0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 2) kick(1'b1, 16'h00FF, 32'h0000_0900, 4'd1, 1'b1);
            chk("wait1_req", {31'h0, memReq}, 32'h1);
            chk("wait1_addr", memAddr, 32'h0000_0300);
            chk("wait1_wd", memWriteData, 32'h1000_0001);
            chk("wait1_busy", {31'h0, busy}, 32'h1);
            if (c == 4) memAck = 1'b1;
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start  = 1'b0;
            memAck = 1'b0;
            chk("wait2_addr", memAddr, 32'h0000_0304);
            chk("wait2_wd", memWriteData, 32'h1000_0004);
            chk("wait2_wr", {31'h0, memWrite}, 32'h1);
            chk("wait2_busy", {31'h0, busy}, 32'h1);
            if (c == 4) memAck = 1'b1;
        end
        @(negedge clk);
        chk("wait_done", {31'h0, done}, 32'h1);
        chk("wait_nowb", {31'h0, regWriteEnable}, 32'h0);

        // Address wrap with store writeback
        @(negedge clk);
        kick(1'b0, 16'h0003, 32'hFFFF_FFFC, 4'd5, 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk("wrap_a0", memAddr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_a1", memAddr, 32'h0000_0000);
        chk("wrap_a1_req", {31'h0, memReq}, 32'h1);
        @(negedge clk);
        chk("wrap_wb_dst", {28'h0, regWriteDest}, 32'h5);
        chk("wrap_wb_dat", regWriteData, 32'h0000_0004);
        @(negedge clk);
        chk("wrap_done", {31'h0, done}, 32'h1);

        // Load including the base register: no writeback cycle
        @(negedge clk);
        kick(1'b1, 16'h0009, 32'h0000_0040, 4'd3, 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk("lbase_c1_dst", {28'h0, regWriteDest}, 32'h0);
        @(negedge clk);
        chk("lbase_c2_dst", {28'h0, regWriteDest}, 32'h3);
        chk("lbase_c2_dat", regWriteData, 32'h5500_0044);
        @(negedge clk);
        chk("lbase_done", {31'h0, done}, 32'h1);
        chk("lbase_nowb", {31'h0, regWriteEnable}, 32'h0);

        // Reset in the middle of a transfer
        @(negedge clk);
        memAck = 1'b0;
        kick(1'b1, 16'h00F0, 32'h0000_0400, 4'd2, 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk("mid_req", {31'h0, memReq}, 32'h1);
        chk("mid_addr", memAddr, 32'h0000_0400);
        memAck = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_req", {31'h0, memReq}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_we", {31'h0, regWriteEnable}, 32'h0);
        chk("mid_rst_addr", memAddr, 32'h0);
        chk("mid_rst_wdat", regWriteData, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", {31'h0, busy}, 32'h0);
        chk("post_rst_we", {31'h0, regWriteEnable}, 32'h0);
        chk("post_rst_done", {31'h0, done}, 32'h0);
        kick(1'b0, 16'h0001, 32'h0000_0500, 4'd0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("fresh_addr", memAddr, 32'h0000_0500);
        chk("fresh_wd", memWriteData, 32'h1000_0000);
        @(negedge clk);
        chk("fresh_done", {31'h0, done}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/block_transfer_unit.md
BLOCK_TRANSFER_UNIT -- requirements
Module: block_transfer_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as follows.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous active-low reset.
REQ-004 start  in  1  one-cycle request to begin a block transfer; sampled only in IDLE.
REQ-005 isLoad  in  1  1 = load-multiple (memory to registers), 0 = store-multiple (registers to memory).
REQ-006 regList  in  16  register mask; bit n selects Rn.
REQ-007 baseAddr  in  32  start address; baseReg  in  4  base register index; writeBack  in  1  write final address to baseReg.
REQ-008 regReadAddr  out  4  register-file read index; regReadData  in  32  combinational read data for regReadAddr.
REQ-009 regWriteEnable  out  1, regWriteDest  out  4, regWriteData  out  32  register-file write port.
REQ-010 memReq  out  1, memWrite  out  1, memAddr  out  32, memWriteData  out  32  memory request; memAck  in  1, memReadData  in  32  response.
REQ-011 busy  out  1  transfer in progress; done  out  1  one-cycle completion pulse; pcLoad  out  1  one-cycle pulse when R15 is loaded.

Function
REQ-012 The FSM SHALL have states IDLE, XFER, WRBACK, DONE.
REQ-013 IDLE: on start=1, latch regList, baseAddr, baseReg, isLoad, writeBack; go to XFER if regList!=0, else DONE.
REQ-014 start outside IDLE SHALL be ignored; latched inputs SHALL NOT change until IDLE is re-entered.
REQ-015 XFER: current register = lowest set bit of remaining mask; memReq=1, memAddr=current address, memWrite=!isLoad.
REQ-016 memReq, memAddr, memWrite, memWriteData SHALL stay stable every cycle until memAck=1.
REQ-017 Store: regReadAddr=current register; memWriteData=regReadData (combinational).
REQ-018 Load: in the memAck cycle, regWriteEnable=1, regWriteDest=current register, regWriteData=memReadData.
REQ-019 pcLoad SHALL be 1 exactly in the memAck cycle of a load into R15.
REQ-020 On memAck: clear current bit, address += 4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-021 After the last ack: go to WRBACK if writeBack=1 and not (isLoad and baseReg in regList), else DONE.
REQ-022 WRBACK (one cycle): regWriteEnable=1, regWriteDest=baseReg, regWriteData=baseAddr + 4*popcount(regList).
REQ-023 DONE (one cycle): done=1, then IDLE.
REQ-024 busy SHALL be 1 in XFER and WRBACK, 0 in IDLE and DONE.
REQ-025 With immediate acks, total latency from start edge to done = N + (WRBACK?1:0) + 1 cycles, where N = popcount(regList).
REQ-026 In IDLE every output SHALL be 0.

Reset
REQ-027 reset=0 SHALL immediately force IDLE and drive all outputs to 0, including mid-transfer; no partial writeback.
REQ-028 After reset release, the first start SHALL be honoured on the next rising edge.

Structure
REQ-029 A shared package SHALL hold the FSM state enumeration, REG_PC=15, and WORD_BYTES=4.
REQ-030 Lowest-set-bit selection SHALL be a sub-module, priority_encoder16 (16-bit mask in, 4-bit index plus valid out).

Verification
REQ-031 STM, regList=0x0005, baseAddr=0x100, memAck always 1 -> two requests: R0 at 0x100, then R2 at 0x104; done on cycle 3; no register writes.
REQ-032 LDM, regList=0x8002, baseAddr=0x200, baseReg=3, writeBack=1 -> R1=mem[0x200]; R15=mem[0x204] with pcLoad pulse; R3=0x208; done on cycle 4.
REQ-033 regList=0 with start -> done next cycle; memReq never asserted.
REQ-034 memAck delayed 3 cycles per request -> memReq, memAddr and memWriteData stable across the wait; busy stays high.
REQ-035 baseAddr=0xFFFFFFFC, regList=0x0003 -> addresses 0xFFFFFFFC then 0x00000000.
REQ-036 reset asserted during XFER -> all outputs 0 in the same cycle; FSM in IDLE; a fresh start completes normally.
